mbist_top: RTL and testbench

// - Memory built-in self-test wrapper: an internal single-port synchronous SRAM, a March C- controller and a result packer.
// - A start pulse runs the full March C- sequence over every word and compares each read against its expected value.
// - Failure details go on a 52-bit result bus, with a done flag for the SoC test/status logic.

---
 rtl/mbist_if.sv | 19 +
 rtl/mbist_top.sv | 258 +++++++++++++++++++++++++
 tb/tb_mbist_top.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mbist_if.sv
// MBIST control/status bundle between the SoC test logic and mbist_top.
// The master side drives the start request; the slave side (mbist_top) returns done and results.
interface mbist_if;
    logic        MBIST_start;
    logic        MBIST_done;
    logic [51:0] DATA_out;

    modport master (
        output MBIST_start,
        input  MBIST_done,
        input  DATA_out
    );

    modport slave (
        input  MBIST_start,
        output MBIST_done,
        output DATA_out
    );
endinterface

// File: rtl/mbist_top.sv
// March C- memory BIST: internal single-port SRAM, sequencer, comparator and result packer.
// Optional macro MBIST_FAULT_INJECT_EN plants a stuck-at-1 on word 5 bit 0 plus a comparator model check.
module mbist_top #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic   clk,
    input  logic   rstn,
    mbist_if.slave bus
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [2:0]          elem_r;
    logic [ADDR_W-1:0]   idx_r;
    logic                phase_r;
    logic [1:0]          drain_cnt_r;

    logic                op_we_s;
    logic                op_re_s;
    logic                op_down_s;
    logic                word_done_s;
    logic [ADDR_W-1:0]   op_addr_s;
    logic [DATA_W-1:0]   op_wdata_s;
    logic [DATA_W-1:0]   op_exp_s;
    logic                run_end_s;
    logic                start_ok_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [DATA_W-1:0]   read_word_s;
    logic [DATA_W-1:0]   rdata_r;

    logic                rd_pend_r;
    logic [DATA_W-1:0]   exp_p_r;
    logic [ADDR_W-1:0]   addr_p_r;
    logic [2:0]          elem_p_r;
    logic                cmp_fail_s;

    logic [3:0]          fail_elem_r;
    logic [7:0]          fail_addr_r;
    logic [15:0]         fail_rdata_r;
    logic [15:0]         fail_exp_r;
    logic [7:0]          fail_cnt_r;
    logic                done_r;

    function automatic logic [DATA_W-1:0] pattern(input logic one_v);
        pattern = one_v ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    endfunction

    // Decode the current March element/phase into one SRAM operation.
    always_comb begin
        op_we_s     = 1'b0;
        op_re_s     = 1'b0;
        op_down_s   = 1'b0;
        word_done_s = 1'b0;
        op_wdata_s  = pattern(1'b0);
        op_exp_s    = pattern(1'b0);
        case (elem_r)
            3'd0: begin
                op_we_s     = 1'b1;
                word_done_s = 1'b1;
            end
            3'd1, 3'd3: begin
                op_down_s   = (elem_r == 3'd3);
                word_done_s = phase_r;
                if (phase_r) begin
                    op_we_s    = 1'b1;
                    op_wdata_s = pattern(1'b1);
                end else begin
                    op_re_s  = 1'b1;
                    op_exp_s = pattern(1'b0);
                end
            end
            3'd2, 3'd4: begin
                op_down_s   = (elem_r == 3'd4);
                word_done_s = phase_r;
                if (phase_r) begin
                    op_we_s    = 1'b1;
                    op_wdata_s = pattern(1'b0);
                end else begin
                    op_re_s  = 1'b1;
                    op_exp_s = pattern(1'b1);
                end
            end
            3'd5: begin
                op_re_s     = 1'b1;
                word_done_s = 1'b1;
            end
            default: begin
                op_we_s = 1'b0;
                op_re_s = 1'b0;
            end
        endcase
        // Descending elements walk N-1..0, which is the bitwise inverse of the index.
        op_addr_s = op_down_s ? ~idx_r : idx_r;
    end

    assign run_end_s  = (state_r == ST_RUN) && word_done_s && (idx_r == LAST_IDX) && (elem_r == 3'd5);
    assign start_ok_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.MBIST_start;

    // Next-state logic for the test sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.MBIST_start) next_state_s = ST_RUN;
                else                 next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (run_end_s) next_state_s = ST_DRAIN;
                else           next_state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 2'd2) next_state_s = ST_DONE;
                else                     next_state_s = ST_DRAIN;
            end
            ST_DONE: begin
                if (bus.MBIST_start) next_state_s = ST_RUN;
                else                 next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rstn) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Element/address/phase walker and drain counter.
    always_ff @(posedge clk) begin
        if (rstn) begin
            elem_r      <= 3'd0;
            idx_r       <= {ADDR_W{1'b0}};
            phase_r     <= 1'b0;
            drain_cnt_r <= 2'd0;
        end else if (start_ok_s) begin
            elem_r      <= 3'd0;
            idx_r       <= {ADDR_W{1'b0}};
            phase_r     <= 1'b0;
            drain_cnt_r <= 2'd0;
        end else if (state_r == ST_RUN) begin
            if (word_done_s) begin
                phase_r <= 1'b0;
                if (idx_r == LAST_IDX) begin
                    idx_r  <= {ADDR_W{1'b0}};
                    elem_r <= elem_r + 3'd1;
                end else begin
                    idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else begin
                phase_r <= 1'b1;
            end
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // SRAM read path, with the optional stuck-at-1 cell on word 5 bit 0.
    always_comb begin
`ifdef MBIST_FAULT_INJECT_EN
        if (op_addr_s == ADDR_W'(5)) read_word_s = mem_r[op_addr_s] | {{(DATA_W-1){1'b0}}, 1'b1};
        else                         read_word_s = mem_r[op_addr_s];
`else
        read_word_s = mem_r[op_addr_s];
`endif
    end

    // Single-port SRAM array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((state_r == ST_RUN) && op_we_s) mem_r[op_addr_s] <= op_wdata_s;
        rdata_r <= read_word_s;
    end

    // Carry read context alongside the one-cycle SRAM latency.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rd_pend_r <= 1'b0;
            exp_p_r   <= {DATA_W{1'b0}};
            addr_p_r  <= {ADDR_W{1'b0}};
            elem_p_r  <= 3'd0;
        end else begin
            rd_pend_r <= (state_r == ST_RUN) && op_re_s;
            exp_p_r   <= op_exp_s;
            addr_p_r  <= op_addr_s;
            elem_p_r  <= elem_r;
        end
    end

    assign cmp_fail_s = rd_pend_r && (rdata_r != exp_p_r);

    // Registered compare: saturating fail count, first-failure capture.
    always_ff @(posedge clk) begin
        if (rstn) begin
            fail_elem_r  <= 4'd0;
            fail_addr_r  <= 8'd0;
            fail_rdata_r <= 16'h0000;
            fail_exp_r   <= 16'h0000;
            fail_cnt_r   <= 8'd0;
        end else if (start_ok_s) begin
            fail_elem_r  <= 4'd0;
            fail_addr_r  <= 8'd0;
            fail_rdata_r <= 16'h0000;
            fail_exp_r   <= 16'h0000;
            fail_cnt_r   <= 8'd0;
        end else if (cmp_fail_s) begin
            if (fail_cnt_r != 8'hFF) fail_cnt_r <= fail_cnt_r + 8'd1;
            else                     fail_cnt_r <= fail_cnt_r;
            if (fail_cnt_r == 8'd0) begin
                fail_elem_r  <= {1'b0, elem_p_r};
                fail_addr_r  <= 8'(addr_p_r);
                fail_rdata_r <= 16'(rdata_r);
                fail_exp_r   <= 16'(exp_p_r);
            end else begin
                fail_elem_r <= fail_elem_r;
            end
        end else begin
            fail_cnt_r <= fail_cnt_r;
        end
    end

`ifdef MBIST_FAULT_INJECT_EN
    // Independent model of the comparator: with only the planted fault, a miss is exactly a 0-read of word 5.
    logic model_fail_s;
    logic model_err_r;
    assign model_fail_s = rd_pend_r && (addr_p_r == ADDR_W'(5)) && (exp_p_r == pattern(1'b0));

    // Sticky flag raised when the comparator and the model disagree.
    always_ff @(posedge clk) begin
        if (rstn)                              model_err_r <= 1'b0;
        else if (model_fail_s != cmp_fail_s)   model_err_r <= 1'b1;
        else                                   model_err_r <= model_err_r;
    end
`endif

    // Done flag tracks entry into and residence in DONE.
    always_ff @(posedge clk) begin
        if (rstn) done_r <= 1'b0;
        else      done_r <= (next_state_s == ST_DONE);
    end

    assign bus.MBIST_done = done_r;
    assign bus.DATA_out   = {fail_elem_r, fail_addr_r, fail_rdata_r, fail_exp_r, fail_cnt_r};

endmodule

// File: tb/tb_mbist_top.sv
// Directed, table-driven bench for mbist_top (64-word SRAM, 643-cycle test).
module tb_mbist_top;

    logic clk = 1'b0;
    logic rstn;

    mbist_if bus ();

    mbist_top #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef MBIST_FAULT_INJECT_EN
    localparam logic [51:0] FULL = {4'd1, 8'd5, 16'h0001, 16'h0000, 8'd3};
    localparam logic [51:0] PART = {4'd1, 8'd5, 16'h0001, 16'h0000, 8'd1};
`else
    localparam logic [51:0] FULL = 52'h0;
    localparam logic [51:0] PART = 52'h0;
`endif

    typedef struct {
        logic        rst;
        logic        start;
        int          hold;
        int          idle;
        logic        exp_done;
        logic [51:0] exp_data;
    } vec_t;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [51:0] got, input logic [51:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        rstn            = 1'b1;
        bus.MBIST_start = 1'b0;

        // {rst, start, hold, idle, done, data}; start edge = first hold edge
        vecs[0]  = '{1'b1, 1'b0, 3, 0,   1'b0, 52'h0};  // reset held 3 cycles
        vecs[1]  = '{1'b0, 1'b0, 0, 100, 1'b0, 52'h0};  // quiet without start
        vecs[2]  = '{1'b0, 1'b1, 1, 642, 1'b0, FULL};   // one edge before done
        vecs[3]  = '{1'b0, 1'b0, 0, 1,   1'b1, FULL};   // done at start+643
        vecs[4]  = '{1'b0, 1'b0, 0, 50,  1'b1, FULL};   // DONE holds
        vecs[5]  = '{1'b0, 1'b1, 1, 0,   1'b0, 52'h0};  // restart from DONE clears
        vecs[6]  = '{1'b0, 1'b0, 0, 642, 1'b0, FULL};
        vecs[7]  = '{1'b0, 1'b0, 0, 1,   1'b1, FULL};   // identical result
        vecs[8]  = '{1'b0, 1'b1, 1, 100, 1'b0, PART};   // mid-run, after first fail
        vecs[9]  = '{1'b0, 1'b1, 1, 0,   1'b0, PART};   // re-pulse ignored (edge 101)
        vecs[10] = '{1'b0, 1'b0, 0, 541, 1'b0, FULL};   // edge 642
        vecs[11] = '{1'b0, 1'b0, 0, 1,   1'b1, FULL};   // still original start+643
        vecs[12] = '{1'b0, 1'b1, 1, 200, 1'b0, PART};
        vecs[13] = '{1'b1, 1'b0, 1, 0,   1'b0, 52'h0};  // reset mid-run
        vecs[14] = '{1'b0, 1'b1, 1, 642, 1'b0, FULL};
        vecs[15] = '{1'b0, 1'b0, 0, 1,   1'b1, FULL};

        for (int i = 0; i < 16; i++) begin
            rstn            = vecs[i].rst;
            bus.MBIST_start = vecs[i].start;
            repeat (vecs[i].hold) tick();
            rstn            = 1'b0;
            bus.MBIST_start = 1'b0;
            repeat (vecs[i].idle) tick();
            cmp($sformatf("vec%0d_done", i), {51'd0, bus.MBIST_done}, {51'd0, vecs[i].exp_done});
            cmp($sformatf("vec%0d_data", i), bus.DATA_out, vecs[i].exp_data);
        end

        // Measure start-to-done latency from DONE, with a bounded wait.
        bus.MBIST_start = 1'b1;
        tick();
        bus.MBIST_start = 1'b0;
        lat = 0;
        while (!bus.MBIST_done && lat < 1000) begin
            tick();
            lat++;
        end
        cmp("latency", 52'(lat), 52'd643);
        cmp("latency_data", bus.DATA_out, FULL);

        // Start during DRAIN must be ignored: restart, run to the last RUN edge, poke start in DRAIN.
        bus.MBIST_start = 1'b1;
        tick();
        bus.MBIST_start = 1'b0;
        repeat (641) tick();
        bus.MBIST_start = 1'b1;
        tick();
        bus.MBIST_start = 1'b0;
        cmp("drain_start_done", {51'd0, bus.MBIST_done}, 52'd0);
        tick();
        cmp("drain_start_done2", {51'd0, bus.MBIST_done}, 52'd1);
        cmp("drain_start_data", bus.DATA_out, FULL);

        // Reset while in DONE.
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        cmp("done_reset_done", {51'd0, bus.MBIST_done}, 52'd0);
        cmp("done_reset_data", bus.DATA_out, 52'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
